// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one decoded ALU operation at a time and returns its result.
//   The request handshake (req_valid/req_ready) captures the operands and the decoded
//   alu_control in IDLE. One cycle is spent in EXEC while the external ALU computes,
//   then the result is held in RESP until it is accepted on the response handshake.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready              request handshake (req_ready high only in IDLE)
//   alu_op, funct3, funct7_5, alu_src  decode fields (alu_src=1 selects imm as operand B)
//   rs1_data, rs2_data, imm          operand sources
//   alu_in1, alu_in2, alu_control    registered drive to the ALU
//   alu_result, zero_flag            combinational ALU return
//   rsp_valid/rsp_ready              response handshake (rsp_valid high only in RESP)
//   rsp_result, rsp_zero, rsp_branch_taken, rsp_illegal  response payload
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  alu_op,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        alu_src,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_result,
  input  logic        zero_flag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_branch_taken,
  output logic        rsp_illegal
);

  localparam logic [3:0] CtrlAnd = 4'b0000;
  localparam logic [3:0] CtrlOr  = 4'b0001;
  localparam logic [3:0] CtrlAdd = 4'b0010;
  localparam logic [3:0] CtrlSub = 4'b0100;
  localparam logic [3:0] CtrlSlt = 4'b1000;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;
  typedef enum logic [1:0] {BrNone, BrEq, BrNe} br_e;

  state_e      state_q, state_d;
  logic [31:0] in1_q, in1_d, in2_q, in2_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic        ill_q, ill_d;
  br_e         br_q, br_d;
  logic [31:0] res_q, res_d;
  logic        zero_q, zero_d, taken_q, taken_d, rsp_ill_q, rsp_ill_d;

  logic [3:0]  dec_ctrl;
  logic        dec_ill;
  br_e         dec_br;

  // Instruction decode of the request fields.
  always_comb begin
    dec_ctrl = CtrlAnd;
    dec_ill  = 1'b0;
    dec_br   = BrNone;
    unique case (alu_op)
      2'b00: dec_ctrl = CtrlAdd;
      2'b01: begin
        dec_ctrl = CtrlSub;
        if (funct3 == 3'b000)      dec_br = BrEq;
        else if (funct3 == 3'b001) dec_br = BrNe;
      end
      2'b10: begin
        unique case (funct3)
          // funct7_5 only selects SUB for register operands; immediates always add.
          3'b000:  dec_ctrl = (funct7_5 && !alu_src) ? CtrlSub : CtrlAdd;
          3'b111:  dec_ctrl = CtrlAnd;
          3'b110:  dec_ctrl = CtrlOr;
          3'b010:  dec_ctrl = CtrlSlt;
          default: dec_ill  = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    ctrl_d    = ctrl_q;
    ill_d     = ill_q;
    br_d      = br_q;
    res_d     = res_q;
    zero_d    = zero_q;
    taken_d   = taken_q;
    rsp_ill_d = rsp_ill_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          in1_d   = rs1_data;
          in2_d   = alu_src ? imm : rs2_data;
          ctrl_d  = dec_ctrl;
          ill_d   = dec_ill;
          br_d    = dec_br;
          state_d = StExec;
        end
      end
      StExec: begin
        // Illegal ops report a forced zero result regardless of what the ALU returns.
        res_d     = ill_q ? 32'd0 : alu_result;
        zero_d    = ill_q | zero_flag;
        taken_d   = ((br_q == BrEq) && zero_flag) || ((br_q == BrNe) && !zero_flag);
        rsp_ill_d = ill_q;
        state_d   = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      in1_q     <= 32'd0;
      in2_q     <= 32'd0;
      ctrl_q    <= CtrlAnd;
      ill_q     <= 1'b0;
      br_q      <= BrNone;
      res_q     <= 32'd0;
      zero_q    <= 1'b0;
      taken_q   <= 1'b0;
      rsp_ill_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      ctrl_q    <= ctrl_d;
      ill_q     <= ill_d;
      br_q      <= br_d;
      res_q     <= res_d;
      zero_q    <= zero_d;
      taken_q   <= taken_d;
      rsp_ill_q <= rsp_ill_d;
    end
  end

  assign alu_in1          = in1_q;
  assign alu_in2          = in2_q;
  assign alu_control      = ctrl_q;
  assign rsp_result       = res_q;
  assign rsp_zero         = zero_q;
  assign rsp_branch_taken = taken_q;
  assign rsp_illegal      = rsp_ill_q;

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, reset: asynchronous assertion, active-low.
REQ-003 SHALL have req_valid input 1 and req_ready output 1: request handshake; a transfer occurs on a clk edge with both high.
REQ-004 SHALL have alu_op input 2, funct3 input 3, funct7_5 input 1, alu_src input 1: decode fields (alu_src=1 selects imm as operand B).
REQ-005 SHALL have rs1_data input 32, rs2_data input 32, imm input 32: operand sources.
REQ-006 SHALL have alu_in1 output 32, alu_in2 output 32, alu_control output 4: registered drive to the ALU.
REQ-007 SHALL have alu_result input 32 and zero_flag input 1: combinational ALU return.
REQ-008 SHALL have rsp_valid output 1 and rsp_ready input 1: response handshake.
REQ-009 SHALL have rsp_result output 32, rsp_zero output 1, rsp_branch_taken output 1, rsp_illegal output 1: response payload.

Function
REQ-010 SHALL implement FSM states IDLE, EXEC, RESP; only IDLE drives req_ready=1; only RESP drives rsp_valid=1.
REQ-011 SHALL, on IDLE transfer, register alu_in1=rs1_data, alu_in2=(alu_src ? imm : rs2_data), decoded alu_control, and go to EXEC.
REQ-012 SHALL decode alu_op=00 to 0010 (ADD) and alu_op=01 to 0100 (SUB), regardless of funct3/funct7_5.
REQ-013 SHALL decode alu_op=10 by funct3: 000 -> 0100 if funct7_5=1 and alu_src=0, else 0010; 111 -> 0000; 110 -> 0001; 010 -> 1000.
REQ-014 SHALL treat alu_op=11 and alu_op=10 with any other funct3 as illegal: alu_control=0000, rsp_illegal=1, rsp_result=0, rsp_zero=1, rsp_branch_taken=0.
REQ-015 SHALL spend exactly one cycle in EXEC, then on the next edge capture alu_result to rsp_result and zero_flag to rsp_zero, and go to RESP.
REQ-016 SHALL set rsp_branch_taken only for alu_op=01: funct3=000 -> zero_flag; funct3=001 -> !zero_flag; other funct3 -> 0 (not illegal).
REQ-017 SHALL hold rsp_valid and all rsp_* payload stable in RESP until rsp_ready=1, then go to IDLE on that edge.
REQ-018 SHALL give latency 2 edges from request transfer to rsp_valid high; minimum initiation interval 3 cycles (no overlap).
REQ-019 SHALL ignore req_valid and all request fields outside IDLE; the request is not consumed.
REQ-020 SHALL hold alu_in1, alu_in2, alu_control stable from request capture through RESP exit, then keep last values in IDLE.
REQ-021 SHALL keep rsp_* payload unchanged in IDLE and EXEC (last response value).

Reset
REQ-022 SHALL, while rst_n=0, force state IDLE, and req_ready=1, rsp_valid=0.
REQ-023 SHALL reset alu_in1, alu_in2, rsp_result to 0, alu_control to 0000, and rsp_zero, rsp_branch_taken, rsp_illegal to 0.
REQ-024 SHALL abandon any in-flight request on reset mid-EXEC or mid-RESP with no response produced; first post-reset transfer behaves per REQ-011.

Verification
REQ-025 R-type ADD: alu_op=10, funct3=000, funct7_5=0, rs1=5, rs2=7 -> alu_control=0010 during EXEC, rsp_valid after 2 edges, rsp_result=12, rsp_zero=0.
REQ-026 Immediate path: alu_op=10, funct3=000, funct7_5=1, alu_src=1, rs1=10, imm=3 -> alu_control=0010 (not SUB), rsp_result=13.
REQ-027 Branches: alu_op=01, funct3=000, rs1=rs2=9 -> rsp_result=0, rsp_zero=1, rsp_branch_taken=1; same with funct3=001 -> rsp_branch_taken=0.
REQ-028 Illegal: alu_op=11 -> alu_control=0000, rsp_illegal=1, rsp_result=0, rsp_zero=1; alu_op=10, funct3=100 -> same response.
REQ-029 Backpressure: hold rsp_ready=0 for 5 cycles in RESP while toggling req_valid and request fields -> rsp_* and alu_* stable, req_ready=0; rsp_ready=1 -> IDLE next edge.
REQ-030 Reset mid-operation: assert rst_n=0 during EXEC -> outputs per REQ-023 immediately (async), no rsp_valid after release; next request (AND 0xF0F0 & 0xFF00) -> rsp_result=0x0000F000.
